data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter that shares the single-ported data memory between port A (processor load/store stage) and port B (loader/debug master). It accepts one request per grant, drives the memory's address, write-data, write-enable and read-enable lines for exactly one cycle, then returns a registered acknowledge and read data to the winning requester. Arbitration is round-robin, so neither port can starve the other. The block sits between the requesters and the data memory; the memory's read path is combinational and its write commits on the rising clock edge.

## Interface
- ADDR_W, 12, address width passed through to memory
- DATA_W, 16, data word width
- A_FIRST, 1, priority holder after reset: 1 = port A, 0 = port B
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- a_req  in  1  port A request; held high until a_ack is seen
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req is high
- a_addr  in  ADDR_W  port A word address; stable while a_req is high
- a_wdata  in  DATA_W  port A write data; stable while a_req is high
- a_ack  out  1  one-cycle completion pulse to port A
- a_rdata  out  DATA_W  port A read data; valid while a_ack is high
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for port B
- data_store_address  out  ADDR_W  memory address
- register  out  DATA_W  memory write data
- mem_write  out  1  memory write enable
- data_mem_read  out  1  memory read enable
- data_memory_readed  in  DATA_W  memory read data, combinational from address
- busy  out  1  high in the GRANT and RESP states

## Operation
- The FSM has three states: IDLE, GRANT, RESP. A 1-bit register `sel` holds the port being served. A 1-bit register `prio` holds the port that wins a tie.
- IDLE: outputs are inactive.
  - Only a_req high: go to GRANT with sel=A.
  - Only b_req high: go to GRANT with sel=B.
  - Both high: go to GRANT with sel=prio.
  - Neither high: stay in IDLE.
- GRANT, memory side:
  - data_store_address = sel port's addr.
  - register = sel port's wdata.
  - mem_write = sel_we & ~Reset.
  - data_mem_read = ~sel_we.
- GRANT, end-of-cycle actions:
  - On the edge that ends GRANT, capture data_memory_readed into the sel port's rdata register. Capture only on reads; the rdata register holds its value on writes.
  - Set prio to the port other than sel.
  - Go to RESP.
- RESP: the sel port's ack is high and the memory lines are inactive. The next state is decided as follows:
  - If the other port's req is high: go to GRANT with sel = other port.
  - Otherwise: go to IDLE.
  - The served port's req is ignored in RESP, so the same port can never be served twice back-to-back without passing through IDLE.
- Inactive memory side: mem_write=0, data_mem_read=0, data_store_address=0, register=0.
- Only one ack can be high in any cycle. Ack goes only to the port that was granted.
- Addresses and data pass through unchanged; address range checking is not part of this block.
- Requester rule: the requester holds req and its fields stable from assertion through the cycle in which its ack is high. Dropping req before ack is a protocol violation. The arbiter behaviour is then unspecified, but the current transaction still completes.

## Timing
- Reset values:
  - state=IDLE, sel=A, prio=A_FIRST.
  - a_ack=0, b_ack=0, busy=0, a_rdata=0, b_rdata=0.
  - All memory outputs inactive.
- Latency: req is sampled high in IDLE in cycle t. GRANT is cycle t+1; the write commits, or the read is captured, at the end of t+1. ack is high in cycle t+2.
- Throughput:
  - One port alone: one transaction per 3 cycles (IDLE, GRANT, RESP).
  - Both ports continuously requesting: the ports alternate, with GRANT/RESP pairs and one transaction per 2 cycles.
- Reset high in any cycle:
  - mem_write is forced to 0 in that cycle, so a write in a GRANT cycle coinciding with Reset is dropped.
  - The next state is IDLE and no ack is issued for the aborted transaction.
- Simultaneous requests in IDLE are resolved by prio only. prio changes only at the end of GRANT.

## Test plan
- Reset, then a_req=1, a_we=1, a_addr=0x003, a_wdata=0xBEEF:
  - mem_write=1 in cycle t+1 only; a_ack=1 in t+2 only.
  - A later a_req=1, a_we=0, a_addr=0x003 returns a_rdata=0xBEEF with a_ack.
- a_req and b_req rise in the same cycle after reset, both reads, with A_FIRST=1:
  - A is granted first and b_ack comes 2 cycles after a_ack.
  - A later simultaneous pair grants B first.
- Both ports hold req continuously for 8 transactions: acks alternate A,B,A,B,… with one ack every 2 cycles and never both high together.
- Only b_req, held high: B's next grant comes after an IDLE cycle, with a 3-cycle period.
- Reset asserted during a B write GRANT (b_wdata=0x1234, b_addr=0x005):
  - mem_write=0 in that cycle, b_ack is never pulsed, and the state is IDLE.
  - A subsequent read of 0x005 returns the prior contents.
- A write followed by a read on the other port in back-to-back GRANT cycles: the read sees the newly written word.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between port A and port B.
// One request per grant: IDLE -> GRANT (memory access) -> RESP (ack + read data).
module data_memory_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter bit          A_FIRST = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] data_store_address,
  output logic [DATA_W-1:0] register,
  output logic              mem_write,
  output logic              data_mem_read,
  input  logic [DATA_W-1:0] data_memory_readed,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam logic PORT_A   = 1'b0;
  localparam logic PORT_B   = 1'b1;
  localparam logic PRIO_RST = A_FIRST ? PORT_A : PORT_B;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;
  logic              go;
  logic              go_port;
  logic              go_we;
  logic              a_ack_d, b_ack_d, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;

  // Next-state, next grant and the memory-side values registered for the GRANT cycle
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    go      = 1'b0;
    go_port = sel_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          go      = 1'b1;
          go_port = prio_q;
        end else if (a_req) begin
          go      = 1'b1;
          go_port = PORT_A;
        end else if (b_req) begin
          go      = 1'b1;
          go_port = PORT_B;
        end
      end
      GRANT: begin
        prio_d  = ~sel_q;
        state_d = RESP;
        a_ack_d = (sel_q == PORT_A);
        b_ack_d = (sel_q == PORT_B);
      end
      RESP: begin
        // The served port's req is ignored here, so it cannot win twice in a row
        if ((sel_q == PORT_A) ? b_req : a_req) begin
          go      = 1'b1;
          go_port = ~sel_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d = GRANT;
      sel_d   = go_port;
    end

    go_we   = (go_port == PORT_B) ? b_we : a_we;
    addr_d  = go ? ((go_port == PORT_B) ? b_addr : a_addr) : '0;
    wdata_d = go ? ((go_port == PORT_B) ? b_wdata : a_wdata) : '0;
    we_d    = go & go_we;
    re_d    = go & ~go_we;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      sel_q   <= PORT_A;
      prio_q  <= PRIO_RST;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      a_ack   <= a_ack_d;
      b_ack   <= b_ack_d;
      busy    <= busy_d;
      // Read data is captured at the end of a read GRANT; writes leave it untouched
      if (state_q == GRANT && re_q) begin
        if (sel_q == PORT_A) a_rdata <= data_memory_readed;
        else                 b_rdata <= data_memory_readed;
      end
    end
  end

  // Reset in a GRANT cycle must drop the pending write in that same cycle
  assign mem_write          = we_q & ~Reset;
  assign data_mem_read      = re_q;
  assign data_store_address = addr_q;
  assign register           = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_data_memory_arbiter;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam bit          A_FIRST = 1'b1;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_ack, b_ack, mem_write, data_mem_read, busy;
  logic [DATA_W-1:0] a_rdata, b_rdata, register, data_memory_readed;
  logic [ADDR_W-1:0] data_store_address;

  int vectors = 0;
  int miscompares = 0;

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .A_FIRST(A_FIRST)) dut (
    .Clock(Clock), .Reset(Reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .data_store_address(data_store_address), .register(register), .mem_write(mem_write),
    .data_mem_read(data_mem_read), .data_memory_readed(data_memory_readed), .busy(busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 16'(i * 7 + 3);
  endfunction

  // Memory environment: combinational read, write on rising edge
  logic [DATA_W-1:0] envmem [0:4095];
  bit                wr_valid [0:4095];
  always @(posedge Clock) begin
    if (mem_write) begin
      envmem[data_store_address]   <= register;
      wr_valid[data_store_address] <= 1'b1;
    end
  end
  assign data_memory_readed = wr_valid[data_store_address] ? envmem[data_store_address]
                                                           : init_word(int'(data_store_address));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: -1 = none, 0 = port A, 1 = port B
  int                g = -1, ack = -1, tie = 0, ng, nack;
  logic [ADDR_W-1:0] gaddr = '0;
  logic [DATA_W-1:0] gwdata = '0;
  logic              gwe = 1'b0;
  logic [DATA_W-1:0] e_rd [2];
  logic [DATA_W-1:0] shadow [int];
  bit                model_on = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      g = -1; ack = -1; tie = A_FIRST ? 0 : 1;
      e_rd[0] = '0; e_rd[1] = '0;
      model_on = 1'b1;
    end else begin
      ng = -1; nack = -1;
      if (g >= 0) begin
        if (gwe) shadow[int'(gaddr)] = gwdata;
        else e_rd[g] = shadow.exists(int'(gaddr)) ? shadow[int'(gaddr)] : init_word(int'(gaddr));
        tie = 1 - g;
        nack = g;
      end else if (ack >= 0) begin
        if ((ack == 0) ? b_req : a_req) ng = 1 - ack;
      end else if (a_req && b_req) ng = tie;
      else if (a_req) ng = 0;
      else if (b_req) ng = 1;
      if (ng >= 0) begin
        gaddr  = (ng == 1) ? b_addr : a_addr;
        gwdata = (ng == 1) ? b_wdata : a_wdata;
        gwe    = (ng == 1) ? b_we : a_we;
      end
      g = ng; ack = nack;
    end
  end

  always @(negedge Clock) begin
    if (model_on) begin
      chk("a_ack", 32'(a_ack), 32'(ack == 0));
      chk("b_ack", 32'(b_ack), 32'(ack == 1));
      chk("busy", 32'(busy), 32'(g >= 0 || ack >= 0));
      chk("mem_write", 32'(mem_write), 32'(g >= 0 && gwe && !Reset));
      chk("data_mem_read", 32'(data_mem_read), 32'(g >= 0 && !gwe));
      chk("address", 32'(data_store_address), (g >= 0) ? 32'(gaddr) : 32'd0);
      chk("register", 32'(register), (g >= 0) ? 32'(gwdata) : 32'd0);
      chk("a_rdata", 32'(a_rdata), 32'(e_rd[0]));
      chk("b_rdata", 32'(b_rdata), 32'(e_rd[1]));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    int nacks, last, prev, gap;
    tick(); tick();
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    Reset = 1'b0;

    // A write 0xBEEF to 0x003, then read it back
    a_req = 1; a_we = 1; a_addr = 12'h003; a_wdata = 16'hBEEF;
    tick();
    chk("t1_grant_we", 32'(mem_write), 1);
    chk("t1_grant_ack", 32'(a_ack), 0);
    tick();
    chk("t1_ack", 32'(a_ack), 1);
    chk("t1_resp_we", 32'(mem_write), 0);
    a_req = 0;
    tick();
    chk("t1_idle_ack", 32'(a_ack), 0);
    a_req = 1; a_we = 0;
    tick();
    chk("t1_rd_en", 32'(data_mem_read), 1);
    tick();
    chk("t1_rd_ack", 32'(a_ack), 1);
    chk("t1_rdata", 32'(a_rdata), 32'hBEEF);
    a_req = 0;
    tick();

    // Simultaneous reads after reset: A first, B two cycles later
    Reset = 1; tick(); Reset = 0;
    a_req = 1; a_we = 0; a_addr = 12'h010;
    b_req = 1; b_we = 0; b_addr = 12'h011;
    tick();
    chk("t2_first_addr", 32'(data_store_address), 32'h010);
    tick();
    chk("t2_a_ack", 32'(a_ack), 1);
    chk("t2_b_ack_early", 32'(b_ack), 0);
    a_req = 0;
    tick();
    chk("t2_second_addr", 32'(data_store_address), 32'h011);
    tick();
    chk("t2_b_ack", 32'(b_ack), 1);
    chk("t2_b_rdata", 32'(b_rdata), 32'h007A);
    chk("t2_a_rdata", 32'(a_rdata), 32'h0073);
    b_req = 0;
    tick();
    // One A-only transaction leaves priority with B
    a_req = 1; a_addr = 12'h012;
    tick(); tick();
    chk("t2_solo_rdata", 32'(a_rdata), 32'h0081);
    a_req = 0;
    tick();
    a_req = 1; b_req = 1; b_addr = 12'h013;
    tick();
    chk("t2_b_first_addr", 32'(data_store_address), 32'h013);
    tick();
    chk("t2_b_first_ack", 32'(b_ack), 1);
    chk("t2_b_first_rdata", 32'(b_rdata), 32'h0088);
    b_req = 0;
    tick(); tick();
    chk("t2_a_second_ack", 32'(a_ack), 1);
    a_req = 0;
    tick();

    // Both ports held: 8 alternating acks, one every 2 cycles
    a_req = 1; a_addr = 12'h030; b_req = 1; b_addr = 12'h031;
    nacks = 0; last = 0; prev = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_ack || b_ack) begin
        chk("t3_one_ack", 32'(a_ack & b_ack), 0);
        if (nacks > 0) begin
          chk("t3_alternate", 32'(b_ack), 32'(1 - prev));
          gap = i - last;
          chk("t3_gap", 32'(gap), 2);
        end
        prev = b_ack ? 1 : 0;
        last = i;
        nacks++;
        if (nacks == 8) begin
          a_req = 0; b_req = 0;
          break;
        end
      end
    end
    chk("t3_count", 32'(nacks), 8);
    a_req = 0; b_req = 0;
    tick(); tick();

    // B alone, held: period of 3 cycles
    b_req = 1; b_we = 0; b_addr = 12'h040;
    nacks = 0; last = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (b_ack) begin
        if (nacks > 0) begin
          gap = i - last;
          chk("t4_period", 32'(gap), 3);
        end
        last = i;
        nacks++;
        if (nacks == 4) begin
          b_req = 0;
          break;
        end
      end
    end
    chk("t4_count", 32'(nacks), 4);
    b_req = 0;
    tick(); tick();

    // Reset during a B write GRANT drops the write and the ack
    b_req = 1; b_we = 1; b_addr = 12'h005; b_wdata = 16'h1234;
    tick();
    chk("t5_grant_we", 32'(mem_write), 1);
    Reset = 1;
    #1;
    chk("t5_we_forced", 32'(mem_write), 0);
    tick();
    Reset = 0; b_req = 0; b_we = 0;
    chk("t5_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_ack", 32'(b_ack), 0);
      tick();
    end
    a_req = 1; a_we = 0; a_addr = 12'h005;
    tick(); tick();
    chk("t5_ack", 32'(a_ack), 1);
    chk("t5_prior_data", 32'(a_rdata), 32'h0026);
    a_req = 0;
    tick();

    // B writes 0x020, A reads it in the following GRANT
    b_req = 1; b_we = 1; b_addr = 12'h020; b_wdata = 16'hCAFE;
    a_req = 1; a_we = 0; a_addr = 12'h020;
    tick();
    chk("t6_write", 32'(mem_write), 1);
    tick();
    chk("t6_b_ack", 32'(b_ack), 1);
    b_req = 0; b_we = 0;
    tick();
    chk("t6_read", 32'(data_mem_read), 1);
    tick();
    chk("t6_a_ack", 32'(a_ack), 1);
    chk("t6_rdata", 32'(a_rdata), 32'hCAFE);
    a_req = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
